// File: rtl/inst_burst_responder.sv
// Read-burst responder: turns one AR request into a stream of single-cycle-latency memory
// reads and returns the words through a two-entry skid FIFO with AXI-style valid/ready.
module inst_burst_responder #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e                  state_q, state_d;
    logic                    rst_done_q, rst_done_d;
    logic [ADDR_WIDTH-1:0]   start_q, start_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [8:0]              issue_q, issue_d;
    logic                    inflight_q, inflight_d;
    logic                    infl_last_q, infl_last_d;
    logic [1:0][31:0]        fifo_data_q, fifo_data_d;
    logic [1:0]              fifo_last_q, fifo_last_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;

    logic       ar_hs;
    logic       pop;
    logic [2:0] occupancy;
    logic       unused_araddr;

    assign unused_araddr = ^{araddr[31:ADDR_WIDTH+2], araddr[1:0]};

    assign arready   = (state_q == StIdle) && rst_done_q;
    assign ar_hs     = arvalid && arready;
    assign rvalid    = (count_q != 2'd0);
    assign rdata     = fifo_data_q[rd_ptr_q];
    assign rlast     = rvalid && fifo_last_q[rd_ptr_q];
    assign pop       = rvalid && rready;
    // Words already buffered plus the one in the memory pipe, minus the one leaving now.
    assign occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign mem_en    = (state_q == StRead) && (issue_q <= {1'b0, arlen_q})
                       && (occupancy < 3'(FIFO_DEPTH));
    assign mem_addr  = start_q + ADDR_WIDTH'(issue_q);

    always_comb begin
        state_d     = state_q;
        rst_done_d  = 1'b1;
        start_d     = start_q;
        arlen_d     = arlen_q;
        issue_d     = issue_q;
        inflight_d  = mem_en;
        infl_last_d = mem_en && (issue_q == {1'b0, arlen_q});
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + {1'b0, inflight_q} - {1'b0, pop};

        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    state_d = StRead;
                    start_d = araddr[ADDR_WIDTH+1:2];
                    arlen_d = arlen;
                    issue_d = '0;
                end
            end
            StRead: begin
                if (mem_en) begin
                    issue_d = issue_q + 9'd1;
                end
                if (pop && rlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (inflight_q) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rst_done_q  <= 1'b0;
            start_q     <= '0;
            arlen_q     <= '0;
            issue_q     <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= rst_done_d;
            start_q     <= start_d;
            arlen_q     <= arlen_d;
            issue_q     <= issue_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_burst_responder.sv
// Directed bench for inst_burst_responder; memory returns {16'hC0DE, 2'b00, word address}.
module tb_inst_burst_responder;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   araddr = '0;
    logic [7:0]    arlen = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_data [0:255];
    logic        got_last [0:255];
    int          got_n, first_rv, first_me, last_cyc, stall_viol, timed_out;
    logic        ready_after;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem_en ? {16'hC0DE, 2'b00, mem_addr} : 32'hDEAD_BEEF;

    inst_burst_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .araddr(araddr), .arlen(arlen), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    // Drives one request, applies rpat[(cycle-1)%16] to rready, records beats and timing.
    task automatic do_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [15:0] rpat);
        int k; int w; logic done; logic prev_stall; logic [31:0] prev_data; logic prev_last;
        got_n = 0; first_rv = -1; first_me = -1; last_cyc = -1; stall_viol = 0;
        timed_out = 0; done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b0;
        #1; w = 0;
        while (arready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        if (arready !== 1'b1) timed_out = 1;
        @(posedge clk); #1;
        arvalid = 1'b0; araddr = 32'hFFFF_FFFF; arlen = 8'hFF;
        k = 1;
        while (!done && k < 600) begin
            rready = rpat[(k - 1) % 16];
            #1;
            if (mem_en === 1'b1 && first_me < 0) first_me = k;
            if (rvalid === 1'b1 && first_rv < 0) first_rv = k;
            if (prev_stall && (rvalid !== 1'b1 || rdata !== prev_data || rlast !== prev_last))
                stall_viol++;
            prev_stall = rvalid && !rready; prev_data = rdata; prev_last = rlast;
            if (rvalid === 1'b1 && rready) begin
                if (got_n < 256) begin got_data[got_n] = rdata; got_last[got_n] = rlast; end
                got_n++;
                if (rlast === 1'b1) begin done = 1'b1; last_cyc = k; end
            end
            @(posedge clk); #1; k++;
        end
        if (!done) timed_out = 1;
        rready = 1'b0; #1;
        ready_after = arready;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast got=%b exp=0", rlast); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready got=%b exp=0", arready); end
        @(posedge clk); #1; rst = 1'b1; #1;
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL release_cyc1_arready got=%b exp=0", arready); end
        @(posedge clk); #1;
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL release_cyc2_arready got=%b exp=1", arready); end
    endtask

    task automatic test_basic_burst();
        do_burst(32'h0000_1000, 8'd7, 16'hFFFF);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL basic_timeout got=%0d exp=0", timed_out); end
        checks++; if (got_n !== 8) begin errors++; $display("FAIL basic_beats got=%0d exp=8", got_n); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data[i] !== 32'hC0DE_0400 + i || got_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                         32'hC0DE_0400 + i, (i == 7));
            end
        end
        checks++; if (first_me !== 1) begin errors++; $display("FAIL basic_first_mem_en got=T+%0d exp=T+1", first_me); end
        checks++; if (first_rv !== 3) begin errors++; $display("FAIL basic_first_rvalid got=T+%0d exp=T+3", first_rv); end
        checks++; if (last_cyc !== 10) begin errors++; $display("FAIL basic_last_beat got=T+%0d exp=T+10", last_cyc); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL basic_arready_after got=%b exp=1", ready_after); end
    endtask

    task automatic test_single_beat();
        do_burst(32'hBFC0_0004, 8'd0, 16'hFFFF);
        checks++; if (got_n !== 1 || timed_out !== 0) begin errors++; $display("FAIL single_beats got=%0d exp=1", got_n); end
        checks++; if (got_data[0] !== 32'hC0DE_0001) begin errors++; $display("FAIL single_data got=%h exp=c0de0001", got_data[0]); end
        checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL single_rlast got=%b exp=1", got_last[0]); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", ready_after); end
    endtask

    task automatic test_backpressure();
        do_burst(32'h0000_2000, 8'd7, 16'h6969);
        checks++; if (got_n !== 8 || timed_out !== 0) begin errors++; $display("FAIL bp_beats got=%0d exp=8", got_n); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data[i] !== 32'hC0DE_0800 + i || got_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i],
                         32'hC0DE_0800 + i, (i == 7));
            end
        end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stability got=%0d exp=0", stall_viol); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [0:3];
        exp_w[0] = 32'hC0DE_3FFE; exp_w[1] = 32'hC0DE_3FFF;
        exp_w[2] = 32'hC0DE_0000; exp_w[3] = 32'hC0DE_0001;
        do_burst(32'h0000_FFF8, 8'd3, 16'hFFFF);
        checks++; if (got_n !== 4 || timed_out !== 0) begin errors++; $display("FAIL wrap_beats got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== exp_w[i]) begin
                errors++; $display("FAIL wrap_beat%0d got=%h exp=%h", i, got_data[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n; int w;
        araddr = 32'h0000_0400; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1; #1;
        w = 0;
        while (arready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0; w = 0;
        while (n < 3 && w < 50) begin
            #1; if (rvalid === 1'b1) n++;
            @(posedge clk); #1; w++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL rstmid_pre_beats got=%0d exp=3", n); end
        rst = 1'b0; #1;
        checks++; if (rvalid !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_immediate got=rvalid%b/mem_en%b exp=0/0", rvalid, mem_en); end
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rstmid_arready got=%b exp=0", arready); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++; if (arready !== 1'b0 || rvalid !== 1'b0) begin
            errors++; $display("FAIL rstmid_rel_cyc1 got=arready%b/rvalid%b exp=0/0", arready, rvalid); end
        @(posedge clk); #1;
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rstmid_rel_cyc2 got=%b exp=1", arready); end
        do_burst(32'h0000_0040, 8'd1, 16'hFFFF);
        checks++; if (got_n !== 2 || timed_out !== 0) begin errors++; $display("FAIL rstmid_post_beats got=%0d exp=2", got_n); end
        checks++; if (got_data[0] !== 32'hC0DE_0010 || got_last[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_post0 got=%h/%b exp=c0de0010/0", got_data[0], got_last[0]); end
        checks++; if (got_data[1] !== 32'hC0DE_0011 || got_last[1] !== 1'b1) begin
            errors++; $display("FAIL rstmid_post1 got=%h/%b exp=c0de0011/1", got_data[1], got_last[1]); end
    endtask

    task automatic test_back_to_back();
        int w; int k; int na; int nb; int busy_ready; int a_err; int b_err; int b_first;
        logic done;
        araddr = 32'h0000_0400; arlen = 8'd3; arvalid = 1'b1; rready = 1'b1; #1;
        w = 0;
        while (arready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        araddr = 32'h0000_0800; arlen = 8'd1;
        na = 0; busy_ready = 0; a_err = 0; done = 1'b0; k = 0;
        while (!done && k < 50) begin
            #1;
            if (arready !== 1'b0) busy_ready++;
            if (rvalid === 1'b1) begin
                if (rdata !== 32'hC0DE_0100 + na || rlast !== (na == 3)) a_err++;
                na++;
                if (rlast === 1'b1) done = 1'b1;
            end
            @(posedge clk); #1; k++;
        end
        checks++; if (busy_ready !== 0) begin errors++; $display("FAIL b2b_busy_arready got=%0d exp=0", busy_ready); end
        checks++; if (na !== 4 || a_err !== 0) begin
            errors++; $display("FAIL b2b_first_burst got=%0d beats/%0d bad exp=4/0", na, a_err); end
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        nb = 0; b_err = 0; b_first = -1; done = 1'b0; k = 1;
        while (!done && k < 50) begin
            #1;
            if (rvalid === 1'b1) begin
                if (b_first < 0) b_first = k;
                if (rdata !== 32'hC0DE_0200 + nb || rlast !== (nb == 1)) b_err++;
                nb++;
                if (rlast === 1'b1) done = 1'b1;
            end
            @(posedge clk); #1; k++;
        end
        checks++; if (nb !== 2 || b_err !== 0) begin
            errors++; $display("FAIL b2b_second_burst got=%0d beats/%0d bad exp=2/0", nb, b_err); end
        checks++; if (b_first !== 3) begin errors++; $display("FAIL b2b_second_latency got=T+%0d exp=T+3", b_first); end
        rready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_single_beat();
        test_backpressure();
        test_wrap();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
